// File: rtl/sq_detector.sv
`default_nettype none
// ============================================================================
// Module   : sq_detector
// Brief    : Serial sequence detector; flags and counts every (overlapping)
//            match of the last PAT_W samples against a live pattern.
// Revision : 1.0 - initial release
// ============================================================================
module sq_detector #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             ds,
    input  logic [PAT_W-1:0] setd,
    output logic             dc,
    output logic [CNT_W-1:0] c
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

    // The oldest history bit is shifted out by the same edge that compares,
    // so only PAT_W-1 bits ever need storing.
    logic [PAT_W-2:0]  hist;
    logic [FILL_W-1:0] fill_cnt;
    logic [PAT_W-1:0]  window;
    logic              match;

    always_comb begin
        window = {hist, ds};
        match  = (window == setd) && (fill_cnt >= FILL_LAST);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            hist     <= '0;
            fill_cnt <= '0;
            dc       <= 1'b0;
            c        <= '0;
        end else begin
            hist <= window[PAT_W-2:0];
            if (fill_cnt != FILL_FULL) begin
                fill_cnt <= fill_cnt + FILL_W'(1);
            end
            dc <= match;
            if (match) begin
                c <= c + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sq_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_sq_detector
// Brief    : Scoreboard bench for sq_detector with hand-derived match points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sq_detector;

    logic       clk;
    logic       clrn;
    logic       ds;
    logic [7:0] setd;
    logic       dc;
    logic [3:0] c;

    typedef struct {
        int         idx;
        logic       dc;
        logic [3:0] c;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cnt     = 0;
    int   step_no = 0;

    sq_detector #(.PAT_W(8), .CNT_W(4)) dut (
        .clk  (clk),
        .clrn (clrn),
        .ds   (ds),
        .setd (setd),
        .dc   (dc),
        .c    (c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one sample between edges and queue what the following edge must yield.
    task automatic step(input logic rn, input logic d, input logic [7:0] pat, input logic edc);
        exp_t e;
        @(negedge clk);
        clrn = rn;
        ds   = d;
        setd = pat;
        if (!rn) cnt = 0;
        else if (edc) cnt = cnt + 1;
        step_no = step_no + 1;
        e.idx = step_no;
        e.dc  = edc;
        e.c   = 4'(cnt);
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are valid every cycle, checked just after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests = n_tests + 1;
                if (dc !== e.dc || c !== e.c) begin
                    n_fail = n_fail + 1;
                    $display("FAIL step%0d: dc=%0b c=%0d, expected dc=%0b c=%0d",
                             e.idx, dc, c, e.dc, e.c);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        clrn = 1'b0;
        ds   = 1'b0;
        setd = 8'h00;

        // Held in reset with activity on ds.
        for (int i = 0; i < 3; i++) step(1'b0, 1'(i), 8'h00, 1'b0);

        // All-zero pattern must not match before eight real samples.
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 8'h00, (i == 8));
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Alternating stream 1,0,1,0...: 10101010 hits on even samples from 8.
        for (int i = 1; i <= 12; i++)
            step(1'b1, 1'(i % 2), 8'b1010_1010, (i >= 8) && (i % 2 == 0));
        // Pattern switch: 01010101 hits on odd samples, count continues.
        for (int i = 13; i <= 18; i++)
            step(1'b1, 1'(i % 2), 8'b0101_0101, (i % 2 == 1));
        // Patterns that never occur in an alternating stream.
        for (int i = 19; i <= 24; i++) step(1'b1, 1'(i % 2), 8'b0011_0011, 1'b0);
        for (int i = 25; i <= 28; i++) step(1'b1, 1'(i % 2), 8'b1100_1100, 1'b0);

        // 0,0,1,1,0,0,1,1 matches only on its last bit.
        begin
            logic [7:0] seq;
            seq = 8'b0011_0011;
            for (int k = 7; k >= 0; k--)
                step(1'b1, seq[k], 8'b0011_0011, (k == 0));
        end

        // Constant ones: the preceding ...,1,1 tail lets the 6th one match; c wraps past 15.
        for (int k = 1; k <= 16; k++) step(1'b1, 1'b1, 8'hFF, (k >= 6));

        // Fresh start, build up to dc=1 and c=5.
        step(1'b0, 1'b1, 8'hFF, 1'b0);
        for (int k = 1; k <= 12; k++) step(1'b1, 1'b1, 8'hFF, (k >= 8));

        @(negedge clk);
        n_tests = n_tests + 1;
        if (dc !== 1'b1 || c !== 4'd5) begin
            n_fail = n_fail + 1;
            $display("FAIL pre_async_rst: dc=%0b c=%0d, expected dc=1 c=5", dc, c);
        end
        #1;
        clrn = 1'b0;
        #1;
        n_tests = n_tests + 1;
        if (dc !== 1'b0 || c !== 4'd0) begin
            n_fail = n_fail + 1;
            $display("FAIL async_rst: dc=%0b c=%0d, expected dc=0 c=0", dc, c);
        end

        step(1'b0, 1'b1, 8'hFF, 1'b0);
        step(1'b0, 1'b1, 8'hFF, 1'b0);
        // After release eight fresh samples are needed again.
        for (int k = 1; k <= 9; k++) step(1'b1, 1'b1, 8'hFF, (k >= 8));

        begin
            int guard;
            guard = 0;
            while (exp_q.size() > 0 && guard < 10) begin
                @(posedge clk);
                guard = guard + 1;
            end
            #2;
            if (exp_q.size() > 0) begin
                n_tests = n_tests + 1;
                n_fail  = n_fail + 1;
                $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
